word_packer: RTL and testbench

Width-converting stage that sits directly downstream of a one-deep `FIFO1` buffer on the byte path. It pops narrow `in_width` entries from that FIFO and assembles them into `ratio`-lane words. It pushes each completed word into the next FIFO through the same ENQ/FULL_N handshake. A FLUSH request emits a partial, zero-padded word with a valid-lane count.

---
 rtl/word_packer_if.sv | 25 ++
 rtl/word_packer.sv | 129 ++++++++++++
 tb/tb_word_packer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/word_packer_if.sv
// Handshake bundle for word_packer: upstream FIFO pop side, downstream FIFO push side,
// and the flush request. The packer takes the master view, the environment the slave view.
interface word_packer_if #(
  parameter int in_width = 8,
  parameter int ratio    = 4
);
  logic [in_width-1:0]       IN_D;
  logic                      IN_EMPTY_N;
  logic                      IN_DEQ;
  logic                      FLUSH;
  logic [in_width*ratio-1:0] OUT_D;
  logic [3:0]                OUT_CNT;
  logic                      OUT_ENQ;
  logic                      OUT_FULL_N;

  modport master (
    input  IN_D, IN_EMPTY_N, FLUSH, OUT_FULL_N,
    output IN_DEQ, OUT_D, OUT_CNT, OUT_ENQ
  );

  modport slave (
    output IN_D, IN_EMPTY_N, FLUSH, OUT_FULL_N,
    input  IN_DEQ, OUT_D, OUT_CNT, OUT_ENQ
  );
endinterface

// File: rtl/word_packer.sv
// word_packer: pops in_width entries from an upstream FIFO and assembles them into
// ratio-lane words (lane 0 in the LSBs), pushing each full word downstream. FLUSH emits
// a zero-padded partial word together with its valid-lane count.
module word_packer #(
  parameter int in_width = 8,
  parameter int ratio    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  word_packer_if.master bus
);

  localparam int         W      = in_width * ratio;
  localparam logic [3:0] RATIO4 = 4'(ratio);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [W-1:0]   word_q, word_d;

  logic           kill_s;
  logic           pop_s;
  logic           enq_s;
  logic [3:0]     cnt_pop_s;
  logic [W-1:0]   word_ins_s;

  // Handshake strobes: depend only on registered state and the FIFO status flags,
  // and are forced low whenever a reset or clear is being applied.
  always_comb begin
    kill_s = RST | CLR;
    if (kill_s) begin
      pop_s = 1'b0;
      enq_s = 1'b0;
    end else if (state_q == EMIT) begin
      // A push frees the word register, so the next lane 0 can be popped in the same cycle.
      enq_s = bus.OUT_FULL_N;
      pop_s = bus.OUT_FULL_N & bus.IN_EMPTY_N;
    end else begin
      enq_s = 1'b0;
      pop_s = bus.IN_EMPTY_N;
    end
  end

  // Word register image with the head entry written into lane cnt_q.
  always_comb begin
    word_ins_s = word_q;
    for (int l = 0; l < ratio; l++) begin
      if (4'(l) == cnt_q) begin
        word_ins_s[l*in_width +: in_width] = bus.IN_D;
      end else begin
        word_ins_s[l*in_width +: in_width] = word_q[l*in_width +: in_width];
      end
    end
  end

  // Next-state logic for the FILL/EMIT machine, lane counter and word register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    cnt_pop_s = pop_s ? (cnt_q + 4'd1) : cnt_q;
    if (kill_s) begin
      state_d = FILL;
      cnt_d   = 4'd0;
      word_d  = {W{1'b0}};
    end else begin
      case (state_q)
        FILL: begin
          if (pop_s) begin
            word_d = word_ins_s;
          end else begin
            word_d = word_q;
          end
          cnt_d = cnt_pop_s;
          // A flush never produces an empty word: it needs at least one lane after the pop.
          if (cnt_pop_s == RATIO4) begin
            state_d = EMIT;
          end else if (bus.FLUSH && (cnt_pop_s != 4'd0)) begin
            state_d = EMIT;
          end else begin
            state_d = FILL;
          end
        end
        EMIT: begin
          if (enq_s) begin
            if (pop_s) begin
              // ratio >= 2, so a single lane can only complete a word via FLUSH.
              word_d  = {{(W-in_width){1'b0}}, bus.IN_D};
              cnt_d   = 4'd1;
              state_d = bus.FLUSH ? EMIT : FILL;
            end else begin
              word_d  = {W{1'b0}};
              cnt_d   = 4'd0;
              state_d = FILL;
            end
          end else begin
            // Downstream full: hold everything so OUT_D stays stable.
            word_d  = word_q;
            cnt_d   = cnt_q;
            state_d = EMIT;
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = 4'd0;
          word_d  = {W{1'b0}};
        end
      endcase
    end
  end

  // State registers; synchronous reset/clear is folded into the next-state logic.
  always_ff @(posedge CLK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    word_q  <= word_d;
  end

  assign bus.IN_DEQ  = pop_s;
  assign bus.OUT_ENQ = enq_s;
  assign bus.OUT_D   = word_q;
  assign bus.OUT_CNT = (state_q == EMIT) ? cnt_q : 4'd0;

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer (in_width=8, ratio=4). Inputs change on the falling
// edge; outputs are checked 1 time unit later, before the next rising edge.
module tb_word_packer;

  logic CLK;
  logic RST;
  logic CLR;
  int   total;
  int   bad;

  word_packer_if #(.in_width(8), .ratio(4)) bus ();

  word_packer #(.in_width(8), .ratio(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic c(input logic rs, input logic cl, input logic en, input logic [7:0] d,
                   input logic fn, input logic fl);
    @(negedge CLK);
    RST            = rs;
    CLR            = cl;
    bus.IN_EMPTY_N = en;
    bus.IN_D       = d;
    bus.OUT_FULL_N = fn;
    bus.FLUSH      = fl;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  pat [16];
    logic [31:0] expw [2];
    logic [7:0]  nxt;
    int          n;
    total = 0;
    bad   = 0;

    // Reset: strobes forced low even with data available
    c(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("rst_deq", {31'd0, bus.IN_DEQ}, 32'd0);
    chk("rst_enq", {31'd0, bus.OUT_ENQ}, 32'd0);
    c(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_enq", {31'd0, bus.OUT_ENQ}, 32'd0);
    chk("post_cnt", {28'd0, bus.OUT_CNT}, 32'd0);
    chk("post_d", bus.OUT_D, 32'd0);

    // 1: single word
    for (int k = 0; k < 4; k++) begin
      c(1'b0, 1'b0, 1'b1, 8'(8'h11 * (k + 1)), 1'b1, 1'b0);
      chk("t1_deq", {31'd0, bus.IN_DEQ}, 32'd1);
      chk("t1_enq_early", {31'd0, bus.OUT_ENQ}, 32'd0);
    end
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_enq", {31'd0, bus.OUT_ENQ}, 32'd1);
    chk("t1_d", bus.OUT_D, 32'h44332211);
    chk("t1_cnt", {28'd0, bus.OUT_CNT}, 32'd4);
    chk("t1_deq_empty", {31'd0, bus.IN_DEQ}, 32'd0);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_idle_enq", {31'd0, bus.OUT_ENQ}, 32'd0);
    chk("t1_idle_d", bus.OUT_D, 32'd0);

    // 2: streaming 0x01..0x08 with no bubble
    for (int k = 0; k < 8; k++) begin
      c(1'b0, 1'b0, 1'b1, 8'(k + 1), 1'b1, 1'b0);
      chk("t2_deq", {31'd0, bus.IN_DEQ}, 32'd1);
      chk("t2_enq", {31'd0, bus.OUT_ENQ}, (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) chk("t2_w0", bus.OUT_D, 32'h04030201);
    end
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_enq1", {31'd0, bus.OUT_ENQ}, 32'd1);
    chk("t2_w1", bus.OUT_D, 32'h08070605);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // 3: backpressure for 5 cycles during EMIT
    for (int k = 0; k < 4; k++) c(1'b0, 1'b0, 1'b1, 8'(8'hA1 + k), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      c(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      chk("t3_enq_held", {31'd0, bus.OUT_ENQ}, 32'd0);
      chk("t3_deq_held", {31'd0, bus.IN_DEQ}, 32'd0);
      chk("t3_d_held", bus.OUT_D, 32'hA4A3A2A1);
      chk("t3_cnt_held", {28'd0, bus.OUT_CNT}, 32'd4);
    end
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_enq_rel", {31'd0, bus.OUT_ENQ}, 32'd1);
    chk("t3_d_rel", bus.OUT_D, 32'hA4A3A2A1);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_enq_once", {31'd0, bus.OUT_ENQ}, 32'd0);

    // 4: flush of a partial word, flush with nothing held, flush with a same-cycle pop
    c(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    c(1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("t4_enq_req", {31'd0, bus.OUT_ENQ}, 32'd0);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_enq", {31'd0, bus.OUT_ENQ}, 32'd1);
    chk("t4_d", bus.OUT_D, 32'h0000BBAA);
    chk("t4_cnt", {28'd0, bus.OUT_CNT}, 32'd2);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("t4_empty_flush", {31'd0, bus.OUT_ENQ}, 32'd0);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_no_empty_word", {31'd0, bus.OUT_ENQ}, 32'd0);
    chk("t4_cnt_idle", {28'd0, bus.OUT_CNT}, 32'd0);
    c(1'b0, 1'b0, 1'b1, 8'hCC, 1'b1, 1'b1);
    chk("t4_pop_flush_deq", {31'd0, bus.IN_DEQ}, 32'd1);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_pop_flush_enq", {31'd0, bus.OUT_ENQ}, 32'd1);
    chk("t4_pop_flush_d", bus.OUT_D, 32'h000000CC);
    chk("t4_pop_flush_cnt", {28'd0, bus.OUT_CNT}, 32'd1);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // 5: sparse input, fixed availability pattern holding exactly 8 entries
    pat  = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1,
             8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0};
    expw = '{32'h34333231, 32'h38373635};
    nxt  = 8'h31;
    n    = 0;
    for (int i = 0; i < 18; i++) begin
      logic en;
      en = (i < 16) ? pat[i][0] : 1'b0;
      c(1'b0, 1'b0, en, nxt, 1'b1, 1'b0);
      chk("t5_deq", {31'd0, bus.IN_DEQ}, {31'd0, en});
      if (bus.OUT_ENQ === 1'b1) begin
        chk("t5_word", bus.OUT_D, (n < 2) ? expw[n] : 32'hDEADBEEF);
        n++;
      end
      if (en) nxt = nxt + 8'd1;
    end
    chk("t5_pushes", 32'(n), 32'd2);

    // 6: clear after 3 lanes discards the partial word
    for (int k = 0; k < 3; k++) c(1'b0, 1'b0, 1'b1, 8'(8'h11 * (k + 1)), 1'b1, 1'b0);
    c(1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    chk("t6_clr_deq", {31'd0, bus.IN_DEQ}, 32'd0);
    chk("t6_clr_enq", {31'd0, bus.OUT_ENQ}, 32'd0);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_after_enq", {31'd0, bus.OUT_ENQ}, 32'd0);
    chk("t6_after_d", bus.OUT_D, 32'd0);
    chk("t6_after_cnt", {28'd0, bus.OUT_CNT}, 32'd0);
    for (int k = 0; k < 4; k++) c(1'b0, 1'b0, 1'b1, 8'(8'h11 * (k + 1)), 1'b1, 1'b0);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_enq", {31'd0, bus.OUT_ENQ}, 32'd1);
    chk("t6_d", bus.OUT_D, 32'h44332211);

    // Clear in EMIT with downstream ready: push is suppressed and the word dropped
    for (int k = 0; k < 4; k++) c(1'b0, 1'b0, 1'b1, 8'(8'h51 + k), 1'b1, 1'b0);
    c(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t7_clr_enq", {31'd0, bus.OUT_ENQ}, 32'd0);
    c(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t7_after_enq", {31'd0, bus.OUT_ENQ}, 32'd0);
    chk("t7_after_d", bus.OUT_D, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
